// File: rtl/bcd_counter_n_pkg.sv
// Shared constants and helpers for the multi-digit BCD counter.
// Holds the digit width, the digit limits and the load-value clamp.
package bcd_counter_n_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

  // Non-decimal nibbles (10..15) collapse to 9 so no illegal digit is ever stored.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_counter_n_digit.sv
// One decimal digit: a 4-bit register with reset, clamped load and up/down step.
// The digit wraps 9->0 going up and 0->9 going down.
module bcd_digit
  import bcd_counter_n_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] load_d,
  output logic [BCD_W-1:0] q,
  output logic             is9,
  output logic             is0
);

  function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] d,
                                                input logic             dir);
    if (dir) return (d == BCD_MAX)  ? BCD_ZERO : d + 4'd1;
    else     return (d == BCD_ZERO) ? BCD_MAX  : d - 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)     q <= BCD_ZERO;
    else if (load) q <= bcd_clamp(load_d);
    else if (step) q <= bcd_next(q, up);
  end

  assign is9 = (q == BCD_MAX);
  assign is0 = (q == BCD_ZERO);

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with load, wrap or saturate mode and a
// registered wrap pulse. All digits step on the same edge; no ripple latency.
module bcd_counter_n
  import bcd_counter_n_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  x,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  carry,
  output logic                  at_max,
  output logic                  at_zero
);

  logic [DIGITS-1:0] is9;
  logic [DIGITS-1:0] is0;
  logic [DIGITS-1:0] sel;
  logic [DIGITS-1:0] step;
  logic              terminal;
  logic              count_en;
  logic              carry_p1;

  assign at_max   = &is9;
  assign at_zero  = &is0;
  assign terminal = up ? at_max : at_zero;
  // In saturate mode a step that would wrap is suppressed entirely.
  assign count_en = x & ~load & ~(SATURATE & terminal);
  assign sel      = up ? is9 : is0;

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      // Digit k steps when every lower digit sits at its terminal value.
      localparam logic [DIGITS-1:0] LOWER = DIGITS'((64'd1 << k) - 64'd1);
      assign step[k] = count_en & ((sel & LOWER) == LOWER);

      bcd_digit u_digit (
        .clk    (clk),
        .reset  (reset),
        .step   (step[k]),
        .up     (up),
        .load   (load),
        .load_d (load_val[4*k +: 4]),
        .q      (bcd_out[4*k +: 4]),
        .is9    (is9[k]),
        .is0    (is0[k])
      );
    end
  endgenerate

  // Stage p1: wrap pulse registered alongside the digit update.
  always_ff @(posedge clk) begin
    if (reset) carry_p1 <= 1'b0;
    else       carry_p1 <= x & ~load & terminal & ~SATURATE;
  end

  assign carry = carry_p1;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: three instances (2-digit wrap, 2-digit saturate,
// 4-digit wrap) share stimulus; a decimal model feeds a scoreboard queue.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        reset, x, up, load;
  logic [15:0] lv;
  logic [7:0]  bcd_w, bcd_s;
  logic [15:0] bcd_4;
  logic        c_w, c_s, c_4, mx_w, mx_s, mx_4, zr_w, zr_s, zr_4;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(2), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .x(x), .up(up), .load(load), .load_val(lv[7:0]),
    .bcd_out(bcd_w), .carry(c_w), .at_max(mx_w), .at_zero(zr_w));
  bcd_counter_n #(.DIGITS(2), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .x(x), .up(up), .load(load), .load_val(lv[7:0]),
    .bcd_out(bcd_s), .carry(c_s), .at_max(mx_s), .at_zero(zr_s));
  bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0)) dut_4 (
    .clk(clk), .reset(reset), .x(x), .up(up), .load(load), .load_val(lv),
    .bcd_out(bcd_4), .carry(c_4), .at_max(mx_4), .at_zero(zr_4));

  typedef struct {
    int          id;
    logic [15:0] bcd;
    logic        c;
    logic        mx;
    logic        zr;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   val[3] = '{0, 0, 0};
  int   dig[3] = '{2, 2, 4};
  bit   sat[3] = '{1'b0, 1'b1, 1'b0};
  bit   cy[3]  = '{1'b0, 1'b0, 1'b0};

  function automatic logic [15:0] to_bcd(input int v, input int d);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model(input int i, input bit r, input bit l, input bit xx,
                       input bit u, input logic [15:0] lvv);
    int maxv;
    int nib;
    int v;
    exp_t e;
    maxv = (dig[i] == 4) ? 9999 : 99;
    cy[i] = 1'b0;
    if (r) val[i] = 0;
    else if (l) begin
      v = 0;
      for (int k = dig[i] - 1; k >= 0; k--) begin
        nib = int'(lvv[4*k +: 4]);
        if (nib > 9) nib = 9;
        v = v * 10 + nib;
      end
      val[i] = v;
    end else if (xx) begin
      if (u) begin
        if (val[i] == maxv) begin
          if (!sat[i]) begin val[i] = 0; cy[i] = 1'b1; end
        end else val[i] = val[i] + 1;
      end else begin
        if (val[i] == 0) begin
          if (!sat[i]) begin val[i] = maxv; cy[i] = 1'b1; end
        end else val[i] = val[i] - 1;
      end
    end
    e.id  = i;
    e.bcd = to_bcd(val[i], dig[i]);
    e.c   = cy[i];
    e.mx  = (val[i] == maxv);
    e.zr  = (val[i] == 0);
    sb.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit l, input bit xx, input bit u,
                     input logic [15:0] lvv);
    exp_t e;
    exp_t o;
    reset = r; load = l; x = xx; up = u; lv = lvv;
    for (int i = 0; i < 3; i++) model(i, r, l, xx, u, lvv);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (sb.size() == 0) begin
        $error("FAIL scoreboard_empty dut=%0d observed=none expected=entry", i);
        continue;
      end
      e = sb.pop_front();
      o.id = e.id;
      case (e.id)
        0:       begin o.bcd = {8'h00, bcd_w}; o.c = c_w; o.mx = mx_w; o.zr = zr_w; end
        1:       begin o.bcd = {8'h00, bcd_s}; o.c = c_s; o.mx = mx_s; o.zr = zr_s; end
        default: begin o.bcd = bcd_4;          o.c = c_4; o.mx = mx_4; o.zr = zr_4; end
      endcase
      assert (o.bcd === e.bcd && o.c === e.c && o.mx === e.mx && o.zr === e.zr)
        passed++;
      else
        $error("FAIL dut%0d t=%0t observed bcd=%h carry=%b max=%b zero=%b expected bcd=%h carry=%b max=%b zero=%b",
               e.id, $time, o.bcd, o.c, o.mx, o.zr, e.bcd, e.c, e.mx, e.zr);
    end
  endtask

  initial begin
    reset = 1'b1; x = 1'b0; up = 1'b1; load = 1'b0; lv = '0;
    // reset, then a full 100-step up count through the wrap
    cyc(1, 0, 0, 1, 16'h0000);
    cyc(1, 0, 1, 1, 16'h0000);
    for (int n = 0; n < 100; n++) cyc(0, 0, 1, 1, 16'h0000);
    cyc(0, 0, 0, 1, 16'h0000);
    // load 50, count down, then down-wrap from zero
    cyc(0, 1, 0, 0, 16'h0050);
    for (int n = 0; n < 3; n++) cyc(0, 0, 1, 0, 16'h0000);
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 16'h0000);
    cyc(0, 0, 0, 0, 16'h0000);
    // saturation edges at top and bottom
    cyc(0, 1, 0, 1, 16'h0098);
    for (int n = 0; n < 3; n++) cyc(0, 0, 1, 1, 16'h0000);
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 16'h0000);
    cyc(0, 0, 1, 0, 16'h0000);
    // clamped load wins over x
    cyc(0, 1, 1, 1, 16'hFAFA);
    cyc(0, 0, 0, 1, 16'h0000);
    // reset overrides load and x mid-count
    cyc(1, 0, 0, 1, 16'h0000);
    for (int n = 0; n < 37; n++) cyc(0, 0, 1, 1, 16'h0000);
    cyc(1, 1, 1, 1, 16'h5555);
    cyc(0, 0, 1, 1, 16'h0000);
    cyc(0, 0, 0, 1, 16'h0000);
    cyc(0, 0, 1, 1, 16'h0000);
    // multi-digit cascade across 0999/1000
    cyc(0, 1, 0, 1, 16'h0999);
    cyc(0, 0, 1, 1, 16'h0000);
    for (int n = 0; n < 6; n++) cyc(0, 0, 1, n[0], 16'h0000);
    // random mix of all controls
    for (int n = 0; n < 200; n++)
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          16'($urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
